// File: rtl/muldiv_sequencer.sv
// Sequences one multiply or divide: launch the unit, wait for its end, then commit HI/LO or flag an error.
// Latency: start pulse 1 cycle after request; commit 1 cycle after end; op_ready back 2 cycles after end.
// Backpressure: op_ready is high only in IDLE; requests while busy are dropped, not queued.
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic op_valid,
    input  logic op_is_div,
    input  logic op_src_mem,
    output logic op_ready,
    input  logic abort,
    output logic mult_start,
    input  logic mult_end,
    output logic div_start,
    input  logic div_end,
    input  logic div_0_exception,
    output logic div_or_mult,
    output logic div_src,
    output logic high_write,
    output logic low_write,
    output logic done,
    output logic div0_err,
    output logic timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMMIT,
        S_EXC,
        S_TOUT
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_div_q, is_div_d;
    logic       src_q, src_d;
    logic       unit_end;

    // Only the launched unit's completion is observed.
    assign unit_end = is_div_q ? div_end : mult_end;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            is_div_q <= 1'b0;
            src_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            src_q    <= src_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        src_d    = src_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    is_div_d = op_is_div;
                    src_d    = op_src_mem;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = 8'd0;
                state_d = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Priority: abort, divide-by-zero, completion, then timeout.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (is_div_q && div_0_exception) begin
                    state_d = S_EXC;
                end else if (unit_end) begin
                    state_d = S_COMMIT;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = S_TOUT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_EXC:    state_d = S_IDLE;
            S_TOUT:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign op_ready    = (state_q == S_IDLE);
    assign mult_start  = (state_q == S_LAUNCH) && !is_div_q;
    assign div_start   = (state_q == S_LAUNCH) && is_div_q;
    assign div_or_mult = !is_div_q;
    assign div_src     = src_q;
    assign high_write  = (state_q == S_COMMIT);
    assign low_write   = (state_q == S_COMMIT);
    assign done        = (state_q == S_COMMIT);
    assign div0_err    = (state_q == S_EXC);
    assign timeout_err = (state_q == S_TOUT);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench: two sequencers (TIMEOUT 64 and 8) share stimulus and are each
// compared every cycle against a per-operation outcome model.
module tb_muldiv_sequencer;

    localparam int NEV = 1000;
    localparam logic [9:0] RST_VEC = 10'b1001000000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic op_valid = 1'b0, op_is_div = 1'b0, op_src_mem = 1'b0, abort = 1'b0;
    logic mult_end = 1'b0, div_end = 1'b0, div_0_exception = 1'b0;

    logic r64_ready, r64_ms, r64_ds, r64_dm, r64_src, r64_hw, r64_lw, r64_done, r64_d0, r64_to;
    logic r8_ready, r8_ms, r8_ds, r8_dm, r8_src, r8_hw, r8_lw, r8_done, r8_d0, r8_to;
    logic [9:0] v64, v8;

    int  errs = 0;
    int  checks = 0;
    logic pdiv = 1'b0, psrc = 1'b0;

    always #5 clock = ~clock;

    muldiv_sequencer #(.TIMEOUT(64)) dut64 (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
        .op_src_mem(op_src_mem), .op_ready(r64_ready), .abort(abort),
        .mult_start(r64_ms), .mult_end(mult_end), .div_start(r64_ds), .div_end(div_end),
        .div_0_exception(div_0_exception), .div_or_mult(r64_dm), .div_src(r64_src),
        .high_write(r64_hw), .low_write(r64_lw), .done(r64_done),
        .div0_err(r64_d0), .timeout_err(r64_to)
    );

    muldiv_sequencer #(.TIMEOUT(8)) dut8 (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
        .op_src_mem(op_src_mem), .op_ready(r8_ready), .abort(abort),
        .mult_start(r8_ms), .mult_end(mult_end), .div_start(r8_ds), .div_end(div_end),
        .div_0_exception(div_0_exception), .div_or_mult(r8_dm), .div_src(r8_src),
        .high_write(r8_hw), .low_write(r8_lw), .done(r8_done),
        .div0_err(r8_d0), .timeout_err(r8_to)
    );

    assign v64 = {r64_ready, r64_ms, r64_ds, r64_dm, r64_src, r64_hw, r64_lw, r64_done, r64_d0, r64_to};
    assign v8  = {r8_ready, r8_ms, r8_ds, r8_dm, r8_src, r8_hw, r8_lw, r8_done, r8_d0, r8_to};

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        if (obs !== expv) begin
            errs++;
            $display("FAIL %s: got %b expected %b (rdy ms ds dm src hw lw done d0 to)", tag, obs, expv);
        end
    endtask

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    // Outcome of one operation: terminating WAIT index t and kind (0 abort, 1 div0, 2 commit, 3 timeout).
    // Events are WAIT indices; wa = -1 means abort during the launch cycle.
    function automatic void model(input logic div, input int we, input int wx, input int wa,
                                  input int tmo, output int t, output int k);
        if (wa < 0) begin
            t = -1; k = 0;
            return;
        end
        t = tmo - 1; k = 3;
        if (we <= t) begin t = we; k = 2; end
        if (div && wx <= t) begin t = wx; k = 1; end
        if (wa <= t) begin t = wa; k = 0; end
    endfunction

    function automatic int ret_cycle(input int t, input int k);
        return (k == 0) ? 3 + t : 4 + t;
    endfunction

    // Cycle 0 is the request cycle, 1 the launch, 2..2+t waiting, 3+t the terminal cycle.
    function automatic logic [9:0] exp_vec(input int c, input logic div, input logic src,
                                           input int t, input int k);
        int   tc;
        logic idle, dm, ds;
        tc   = 3 + t;
        idle = (c == 0) || (c >= ret_cycle(t, k));
        dm   = (c == 0) ? !pdiv : !div;
        ds   = (c == 0) ? psrc : src;
        return {idle, (c == 1) && !div, (c == 1) && div, dm, ds,
                (c == tc) && (k == 2), (c == tc) && (k == 2), (c == tc) && (k == 2),
                (c == tc) && (k == 1), (c == tc) && (k == 3)};
    endfunction

    task automatic drive_zero();
        op_valid = 1'b0; op_is_div = 1'b0; op_src_mem = 1'b0; abort = 1'b0;
        mult_end = 1'b0; div_end = 1'b0; div_0_exception = 1'b0;
    endtask

    task automatic run_op(input logic div, input logic src, input int we, input int wx,
                          input int wa, input int rst_at);
        int   t64, k64, t8, k8, r64, r8, last64, j;
        logic inwait, lend;
        model(div, we, wx, wa, 64, t64, k64);
        model(div, we, wx, wa, 8, t8, k8);
        r64    = ret_cycle(t64, k64);
        r8     = ret_cycle(t8, k8);
        last64 = 2 + t64;

        chk($sformatf("t64 req c0 div=%0d", div), v64, exp_vec(0, div, src, t64, k64));
        chk($sformatf("t8 req c0 div=%0d", div), v8, exp_vec(0, div, src, t8, k8));
        op_valid = 1'b1; op_is_div = div; op_src_mem = src;
        abort = rb(); mult_end = rb(); div_end = rb(); div_0_exception = rb();
        @(posedge clock); #1;

        for (int c = 1; c <= r64; c++) begin
            chk($sformatf("t64 c%0d div=%0d we=%0d wx=%0d wa=%0d", c, div, we, wx, wa),
                v64, exp_vec(c, div, src, t64, k64));
            chk($sformatf("t8 c%0d div=%0d we=%0d wx=%0d wa=%0d", c, div, we, wx, wa),
                v8, exp_vec(c, div, src, t8, k8));
            if (c == rst_at) begin
                #2 reset = 1'b0;
                #1;
                chk("t64 async reset", v64, RST_VEC);
                chk("t8 async reset", v8, RST_VEC);
                #1 reset = 1'b1;
                pdiv = 1'b0; psrc = 1'b0;
                drive_zero();
                @(posedge clock); #1;
                return;
            end
            j      = c - 2;
            inwait = (c >= 2) && (c <= last64);
            op_valid   = (c < r8) ? rb() : 1'b0;
            op_is_div  = rb();
            op_src_mem = rb();
            abort      = (c == 2 + wa) || ((c > last64) && rb());
            lend       = inwait ? (j == we) : rb();
            if (div) begin
                div_end         = lend;
                mult_end        = rb();
                div_0_exception = inwait ? (j == wx) : rb();
            end else begin
                mult_end        = lend;
                div_end         = rb();
                div_0_exception = rb();
            end
            @(posedge clock); #1;
        end
        pdiv = div; psrc = src;
        drive_zero();
        @(posedge clock); #1;
    endtask

    initial begin
        int we, wx, wa;
        drive_zero();
        repeat (3) @(posedge clock);
        #1;
        chk("t64 reset state", v64, RST_VEC);
        chk("t8 reset state", v8, RST_VEC);
        reset = 1'b1;

        run_op(1'b0, 1'b0, 32, NEV, NEV, -1);   // mult end 33 cycles after start
        run_op(1'b1, 1'b1, 0, NEV, NEV, -1);    // div from memory, end in first WAIT cycle
        run_op(1'b1, 1'b0, 5, 5, NEV, -1);      // div0 beats same-cycle end
        run_op(1'b0, 1'b0, NEV, NEV, NEV, -1);  // no end: both time out
        run_op(1'b0, 1'b1, 7, NEV, NEV, -1);    // end on last WAIT cycle of short timeout
        run_op(1'b0, 1'b0, 4, NEV, 4, -1);      // abort together with mult_end
        run_op(1'b1, 1'b0, 10, NEV, NEV, -1);   // stray mult_end during div
        run_op(1'b1, 1'b1, NEV, NEV, -1, -1);   // abort during launch
        run_op(1'b0, 1'b1, 3, NEV, 4, -1);      // abort during commit
        run_op(1'b1, 1'b1, NEV, NEV, NEV, 4);   // async reset mid-WAIT
        run_op(1'b0, 1'b0, 2, NEV, NEV, -1);    // normal mult after reset

        for (int n = 0; n < 40; n++) begin
            we = ($urandom_range(0, 3) == 0) ? NEV : int'($urandom_range(0, 70));
            wx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 70)) : NEV;
            wa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) - 1 : NEV;
            run_op(rb(), rb(), we, wx, wa, ($urandom_range(0, 9) == 0) ? 3 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
